pattern_detect_ctrl: RTL

PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

---
 rtl/pattern_detect_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pattern_detect_ctrl.sv
// Serial pattern detector with a bounded detection window and match counter.
// Optional macro PATTERN_DETECT_OVERLAP_EN keeps history after a match so overlapping occurrences count.
module pattern_detect_ctrl #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             start,
   input  logic             abort,
   input  logic             x,
   input  logic             x_valid,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             done
);

   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
   localparam logic [7:0]        PAT_RST8 = 8'b0000_0011;
   localparam logic [PAT_W-1:0]  PAT_RST  = PAT_RST8[PAT_W-1:0];

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [PAT_W-1:0]   pattern_q;
   logic [CNT_W-1:0]   len_q;
   logic [PAT_W-2:0]   history;
   logic [FILL_W-1:0]  fill;
   logic [CNT_W-1:0]   bit_cnt;
   logic [PAT_W-1:0]   window;
   logic               accept;
   logic               last_bit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
      return (v == FILL_MAX) ? v : v + FILL_W'(1);
   endfunction

   assign window   = {history, x};
   assign accept   = (state == S_RUN) && x_valid;
   assign last_bit = accept && ((bit_cnt + CNT_W'(1)) == len_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      match     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (len_q != '0) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            busy  = 1'b1;
            match = accept && (fill == FILL_MAX) && (window == pattern_q);
            // Abort wins over completion: no done pulse for an aborted window.
            if (abort)         state_nxt = S_IDLE;
            else if (last_bit) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern_q   <= PAT_RST;
         len_q       <= '0;
         history     <= '0;
         fill        <= '0;
         bit_cnt     <= '0;
         match_count <= '0;
      end else begin
         if (state == S_IDLE) begin
            if (cfg_we) begin
               pattern_q <= cfg_pattern;
               len_q     <= cfg_len;
            end
            if (start) begin
               history     <= '0;
               fill        <= '0;
               bit_cnt     <= '0;
               match_count <= '0;
            end
         end
         if (accept) begin
            history <= window[PAT_W-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef PATTERN_DETECT_OVERLAP_EN
            fill    <= fill_inc(fill);
`else
            // Without overlap the next match must be built from fresh bits.
            fill    <= match ? '0 : fill_inc(fill);
`endif
            if (match) match_count <= sat_inc(match_count);
         end
      end
   end

endmodule
